// File: rtl/mem_access_arbiter.sv
// Two-port memory access arbiter.
// Port 0 (fetch) and port 1 (data) share a single synchronous memory.
// Ties are broken round-robin. Each transaction walks IDLE -> ACCESS ->
// (WAIT x RD_LAT for reads) -> RESP. Every output is registered.
module mem_access_arbiter #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          chip_select,
   output logic          out_enable,
   output logic          wire_enable,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   // The counter loads RD_LAT-1 and exits WAIT once it reaches zero.
   // The result is exactly RD_LAT WAIT cycles.
   localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       last_grant;
   logic       port_l;
   logic       we_l;
   logic       grant_port;

   // Round-robin winner.
   // A lone requester wins outright.
   // On a tie, the port that was not granted last wins.
   always_comb begin
      grant_port = 1'b0;
      grant_port = req1 & (~req0 | ~last_grant);
   end

   // FSM with registered strobes.
   // The strobes are loaded on the edge that enters ACCESS, so they are high
   // only during ACCESS. They are cleared by default on every other edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= 4'd0;
         last_grant  <= 1'b1;
         port_l      <= 1'b0;
         we_l        <= 1'b0;
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         rdata0      <= '0;
         rdata1      <= '0;
         chip_select <= 1'b0;
         out_enable  <= 1'b0;
         wire_enable <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b0;
      end else begin
         ack0        <= 1'b0;
         ack1        <= 1'b0;
         chip_select <= 1'b0;
         out_enable  <= 1'b0;
         wire_enable <= 1'b0;
         unique case (state)
            IDLE: begin
               if (req0 | req1) begin
                  state       <= ACCESS;
                  busy        <= 1'b1;
                  port_l      <= grant_port;
                  last_grant  <= grant_port;
                  we_l        <= grant_port ? we1 : we0;
                  mem_addr    <= grant_port ? addr1 : addr0;
                  mem_wdata   <= grant_port ? wdata1 : wdata0;
                  chip_select <= 1'b1;
                  out_enable  <= ~(grant_port ? we1 : we0);
                  wire_enable <= grant_port ? we1 : we0;
               end
            end
            ACCESS: begin
               if (we_l) begin
                  state <= RESP;
                  ack0  <= ~port_l;
                  ack1  <= port_l;
               end else begin
                  state    <= WAIT;
                  wait_cnt <= WAIT_INIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state <= RESP;
                  ack0  <= ~port_l;
                  ack1  <= port_l;
                  if (port_l) rdata1 <= mem_rdata;
                  else        rdata0 <= mem_rdata;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter.
// Instance u1 uses RD_LAT=1 and instance u4 uses RD_LAT=4.
// Both instances share all inputs.
module tb_mem_access_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

   logic        a0_1, a1_1, cs_1, oe_1, we_1, busy_1;
   logic [31:0] rd0_1, rd1_1, ma_1, mw_1;
   logic        a0_4, a1_4, cs_4, oe_4, we_4, busy_4;
   logic [31:0] rd0_4, rd1_4, ma_4, mw_4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u1 (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(a0_1), .ack1(a1_1), .rdata0(rd0_1), .rdata1(rd1_1),
      .chip_select(cs_1), .out_enable(oe_1), .wire_enable(we_1),
      .mem_addr(ma_1), .mem_wdata(mw_1), .mem_rdata(mem_rdata), .busy(busy_1));

   mem_access_arbiter #(.AW(32), .DW(32), .RD_LAT(4)) u4 (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(a0_4), .ack1(a1_4), .rdata0(rd0_4), .rdata1(rd1_4),
      .chip_select(cs_4), .out_enable(oe_4), .wire_enable(we_4),
      .mem_addr(ma_4), .mem_wdata(mw_4), .mem_rdata(mem_rdata), .busy(busy_4));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobes never overlap and the two acks never fire together.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("strobe_overlap_u1", {31'd0, oe_1 & we_1}, 32'd0);
         chk("strobe_overlap_u4", {31'd0, oe_4 & we_4}, 32'd0);
         chk("both_acks_u1", {31'd0, a0_1 & a1_1}, 32'd0);
         chk("both_acks_u4", {31'd0, a0_4 & a1_4}, 32'd0);
      end
   end

   initial begin
      reset = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
      step(); step();
      // reset state
      chk("rst_busy", {31'd0, busy_1}, 32'd0);
      chk("rst_cs", {31'd0, cs_1}, 32'd0);
      chk("rst_ack0", {31'd0, a0_1}, 32'd0);
      chk("rst_rdata0", rd0_1, 32'd0);
      chk("rst_mem_addr", ma_1, 32'd0);
      chk("rst_mem_wdata", mw_1, 32'd0);
      chk("rst_busy_u4", {31'd0, busy_4}, 32'd0);
      reset = 1'b0;
      step();

      // single read on port 0, RD_LAT=1
      req0 = 1; addr0 = 32'h10; mem_rdata = 32'hDEADBEEF;
      step();
      chk("rd_access_cs", {31'd0, cs_1}, 32'd1);
      chk("rd_access_oe", {31'd0, oe_1}, 32'd1);
      chk("rd_access_we", {31'd0, we_1}, 32'd0);
      chk("rd_access_addr", ma_1, 32'h10);
      chk("rd_access_busy", {31'd0, busy_1}, 32'd1);
      req0 = 0;
      step();
      chk("rd_wait_cs", {31'd0, cs_1}, 32'd0);
      chk("rd_wait_ack0", {31'd0, a0_1}, 32'd0);
      step();
      chk("rd_resp_ack0", {31'd0, a0_1}, 32'd1);
      chk("rd_resp_ack1", {31'd0, a1_1}, 32'd0);
      chk("rd_resp_rdata0", rd0_1, 32'hDEADBEEF);
      step();
      chk("rd_idle_ack0", {31'd0, a0_1}, 32'd0);
      chk("rd_idle_busy", {31'd0, busy_1}, 32'd0);
      chk("rd_idle_rdata0", rd0_1, 32'hDEADBEEF);

      // single write on port 1
      req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
      step();
      chk("wr_access_cs", {31'd0, cs_1}, 32'd1);
      chk("wr_access_wen", {31'd0, we_1}, 32'd1);
      chk("wr_access_oe", {31'd0, oe_1}, 32'd0);
      chk("wr_access_addr", ma_1, 32'h20);
      chk("wr_access_wdata", mw_1, 32'h12345678);
      req1 = 0;
      step();
      chk("wr_resp_ack1", {31'd0, a1_1}, 32'd1);
      chk("wr_resp_ack0", {31'd0, a0_1}, 32'd0);
      chk("wr_resp_rdata1", rd1_1, 32'd0);
      chk("wr_resp_cs", {31'd0, cs_1}, 32'd0);
      we1 = 0;
      step();
      chk("wr_idle_busy", {31'd0, busy_1}, 32'd0);

      // contention from reset: the grants alternate 0,1,0,1
      reset = 1; req0 = 1; req1 = 1; addr0 = 32'hA0; addr1 = 32'hB0;
      step();
      reset = 0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("cont_grant_addr", ma_1, (i % 2 == 0) ? 32'hA0 : 32'hB0);
         step();
         step();
         chk("cont_ack0", {31'd0, a0_1}, (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_ack1", {31'd0, a1_1}, (i % 2 == 0) ? 32'd0 : 32'd1);
         step();
         step();
      end
      req0 = 0; req1 = 0;

      // RD_LAT=4 read: only the last WAIT cycle's data is captured
      reset = 1;
      step();
      reset = 0;
      step();
      req0 = 1; addr0 = 32'h44; mem_rdata = 32'h1;
      step();
      chk("lat4_access_cs", {31'd0, cs_4}, 32'd1);
      chk("lat4_access_oe", {31'd0, oe_4}, 32'd1);
      req0 = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         mem_rdata = 32'h100 + 32'(k);
         chk("lat4_wait_busy", {31'd0, busy_4}, 32'd1);
         chk("lat4_wait_ack0", {31'd0, a0_4}, 32'd0);
         chk("lat4_wait_cs", {31'd0, cs_4}, 32'd0);
      end
      step();
      chk("lat4_resp_ack0", {31'd0, a0_4}, 32'd1);
      chk("lat4_resp_rdata0", rd0_4, 32'h104);
      chk("lat1_parallel_rdata0", rd0_1, 32'h101);
      mem_rdata = 32'h999;
      step();
      chk("lat4_idle_ack0", {31'd0, a0_4}, 32'd0);
      chk("lat4_hold_rdata0", rd0_4, 32'h104);

      // reset during WAIT aborts the transaction
      req1 = 1; addr1 = 32'h55;
      step();
      req1 = 0;
      step(); step();
      chk("abort_in_wait_busy", {31'd0, busy_4}, 32'd1);
      reset = 1;
      step();
      chk("abort_busy", {31'd0, busy_4}, 32'd0);
      chk("abort_ack1", {31'd0, a1_4}, 32'd0);
      chk("abort_cs", {31'd0, cs_4}, 32'd0);
      chk("abort_oe", {31'd0, oe_4}, 32'd0);
      reset = 0;
      step();
      chk("abort_late_ack1", {31'd0, a1_4}, 32'd0);
      chk("abort_late_busy", {31'd0, busy_4}, 32'd0);
      req1 = 1; mem_rdata = 32'h77;
      step();
      chk("fresh_access_cs", {31'd0, cs_4}, 32'd1);
      chk("fresh_access_addr", ma_4, 32'h55);
      req1 = 0;
      step(); step(); step(); step();
      chk("fresh_wait_ack1", {31'd0, a1_4}, 32'd0);
      step();
      chk("fresh_resp_ack1", {31'd0, a1_4}, 32'd1);
      chk("fresh_resp_rdata1", rd1_4, 32'h77);
      step();

      // req1 dropped during WAIT: ack1 still pulses
      req1 = 1; addr1 = 32'h66; mem_rdata = 32'hCAFE;
      step();
      chk("drop_access_cs", {31'd0, cs_1}, 32'd1);
      step();
      req1 = 0;
      step();
      chk("drop_resp_ack1", {31'd0, a1_1}, 32'd1);
      chk("drop_resp_rdata1", rd1_1, 32'hCAFE);
      step();
      chk("drop_idle_ack1", {31'd0, a1_1}, 32'd0);
      chk("drop_idle_busy", {31'd0, busy_1}, 32'd0);
      step(); step(); step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
